// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory-access stage: funct3 codes, MA FSM states,
// write-back select encodings and access-size helpers.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RW_SEL_ALU = 2'b00;
    localparam logic [1:0] RW_SEL_MEM = 2'b01;
    localparam logic [1:0] RW_SEL_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        WAIT_RD = 2'b10
    } ma_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_t;

    // Byte/half codes coincide for loads and stores; 100/101 are only sized for loads.
    function automatic acc_size_t access_size(input logic [2:0] funct3, input logic is_load);
        acc_size_t size_v;
        case (funct3)
            F3_LB:   size_v = SZ_BYTE;
            F3_LH:   size_v = SZ_HALF;
            F3_LBU:  size_v = is_load ? SZ_BYTE : SZ_WORD;
            F3_LHU:  size_v = is_load ? SZ_HALF : SZ_WORD;
            default: size_v = SZ_WORD;
        endcase
        return size_v;
    endfunction

    function automatic logic is_misaligned(input acc_size_t size, input logic [1:0] addr_lo);
        logic mis_v;
        case (size)
            SZ_HALF: mis_v = addr_lo[0];
            SZ_WORD: mis_v = (addr_lo != 2'b00);
            default: mis_v = 1'b0;
        endcase
        return mis_v;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte enables and replicated write data,
// plus load lane selection with sign/zero extension.
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        unsigned_s;

    assign unsigned_s = funct3[2];

    // Store side: byte enables shifted into place, data replicated across lanes.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (access_size(funct3, 1'b0))
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend by the unsigned bit of funct3.
    always_comb begin
        byte_s    = read_data[7:0];
        half_s    = addr_lo[1] ? read_data[31:16] : read_data[15:0];
        load_data = read_data;
        case (addr_lo)
            2'b00:   byte_s = read_data[7:0];
            2'b01:   byte_s = read_data[15:8];
            2'b10:   byte_s = read_data[23:16];
            2'b11:   byte_s = read_data[31:24];
            default: byte_s = read_data[7:0];
        endcase
        case (access_size(funct3, 1'b1))
            SZ_BYTE: load_data = unsigned_s ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_data = unsigned_s ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default: load_data = read_data;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// RV32I memory-access stage: req/gnt/rvalid data-memory FSM with registered WB outputs.
// Optional misaligned-access trap enabled by defining MA_MISALIGN_TRAP_EN.
module memory_access
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ex_valid,
    output logic              o_ma_ready,
    input  logic [XLEN-1:0]   i_ex_result,
    input  logic [XLEN-1:0]   i_ex_write_data,
    input  logic [2:0]        i_ex_funct3,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_mem_write,
    input  logic              i_ex_mem_to_reg,
    input  logic [1:0]        i_ex_rw_sel,
    input  logic [XLEN-1:0]   i_ex_pc_plus_4,
    input  logic              i_ex_reg_write,
    input  logic [4:0]        i_ex_rd_addr,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    output logic              o_ma_valid,
    output logic              o_ma_reg_write,
    output logic [4:0]        o_ma_rd_addr,
    output logic              o_ma_mem_to_reg,
    output logic [1:0]        o_ma_rw_sel,
    output logic [XLEN-1:0]   o_ma_result,
    output logic [XLEN-1:0]   o_ma_read_data,
    output logic [XLEN-1:0]   o_ma_pc_plus_4
`ifdef MA_MISALIGN_TRAP_EN
    ,
    output logic              o_ma_misaligned
`endif
);

    ma_state_t       state_r, next_state_s;
    logic            is_mem_s, mis_s, req_s;
    logic            capture_s, alu_retire_s, mem_retire_s, trap_s;

    logic [XLEN-1:0] addr_r, store_data_r, pc_plus_4_r;
    logic [2:0]      funct3_r;
    logic            is_load_r, mem_to_reg_r, reg_write_r;
    logic [1:0]      rw_sel_r;
    logic [4:0]      rd_addr_r;
    logic [XLEN-1:0] word_addr_s;

    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_s, load_data_s;

    logic            ma_valid_r, ma_reg_write_r, ma_mem_to_reg_r;
    logic [4:0]      ma_rd_addr_r;
    logic [1:0]      ma_rw_sel_r;
    logic [XLEN-1:0] ma_result_r, ma_read_data_r, ma_pc_plus_4_r;

    assign is_mem_s = i_ex_mem_read | i_ex_mem_write;

`ifdef MA_MISALIGN_TRAP_EN
    logic ma_misaligned_r;
    assign mis_s           = is_misaligned(access_size(i_ex_funct3, i_ex_mem_read), i_ex_result[1:0]);
    assign o_ma_misaligned = ma_misaligned_r;
`else
    assign mis_s = 1'b0;
`endif

    load_store_align u_align (
        .funct3     (funct3_r),
        .addr_lo    (addr_r[1:0]),
        .store_data (store_data_r),
        .read_data  (i_dmem_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .load_data  (load_data_s)
    );

    // State register; reset aborts any outstanding access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        alu_retire_s = 1'b0;
        mem_retire_s = 1'b0;
        trap_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_ex_valid) begin
                    if (!is_mem_s) begin
                        alu_retire_s = 1'b1;
                    end else if (mis_s) begin
                        trap_s = 1'b1;
                    end else begin
                        capture_s    = 1'b1;
                        next_state_s = REQ;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (i_dmem_gnt) begin
                    if (is_load_r) begin
                        next_state_s = WAIT_RD;
                    end else begin
                        mem_retire_s = 1'b1;
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = REQ;
                end
            end
            WAIT_RD: begin
                if (i_dmem_rvalid) begin
                    mem_retire_s = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_RD;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Capture of EX fields for the duration of a memory access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_r       <= {XLEN{1'b0}};
            store_data_r <= {XLEN{1'b0}};
            pc_plus_4_r  <= {XLEN{1'b0}};
            funct3_r     <= 3'b000;
            is_load_r    <= 1'b0;
            mem_to_reg_r <= 1'b0;
            reg_write_r  <= 1'b0;
            rw_sel_r     <= 2'b00;
            rd_addr_r    <= 5'd0;
        end else if (capture_s) begin
            addr_r       <= i_ex_result;
            store_data_r <= i_ex_write_data;
            pc_plus_4_r  <= i_ex_pc_plus_4;
            funct3_r     <= i_ex_funct3;
            is_load_r    <= i_ex_mem_read;
            mem_to_reg_r <= i_ex_mem_to_reg;
            reg_write_r  <= i_ex_reg_write;
            rw_sel_r     <= i_ex_rw_sel;
            rd_addr_r    <= i_ex_rd_addr;
        end
    end

    // WB-facing registers; data fields hold across bubbles, reg_write never does.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ma_valid_r      <= 1'b0;
            ma_reg_write_r  <= 1'b0;
            ma_rd_addr_r    <= 5'd0;
            ma_mem_to_reg_r <= 1'b0;
            ma_rw_sel_r     <= 2'b00;
            ma_result_r     <= {XLEN{1'b0}};
            ma_read_data_r  <= {XLEN{1'b0}};
            ma_pc_plus_4_r  <= {XLEN{1'b0}};
`ifdef MA_MISALIGN_TRAP_EN
            ma_misaligned_r <= 1'b0;
`endif
        end else begin
            ma_valid_r <= alu_retire_s | mem_retire_s | trap_s;
`ifdef MA_MISALIGN_TRAP_EN
            ma_misaligned_r <= trap_s;
`endif
            if (alu_retire_s || trap_s) begin
                ma_reg_write_r  <= alu_retire_s & i_ex_reg_write;
                ma_rd_addr_r    <= i_ex_rd_addr;
                ma_mem_to_reg_r <= i_ex_mem_to_reg;
                ma_rw_sel_r     <= i_ex_rw_sel;
                ma_result_r     <= i_ex_result;
                ma_pc_plus_4_r  <= i_ex_pc_plus_4;
            end else if (mem_retire_s) begin
                ma_reg_write_r  <= reg_write_r;
                ma_rd_addr_r    <= rd_addr_r;
                ma_mem_to_reg_r <= mem_to_reg_r;
                ma_rw_sel_r     <= rw_sel_r;
                ma_result_r     <= addr_r;
                ma_pc_plus_4_r  <= pc_plus_4_r;
                if (is_load_r) begin
                    ma_read_data_r <= load_data_s;
                end
            end else begin
                ma_reg_write_r <= 1'b0;
            end
        end
    end

    assign req_s       = (state_r == REQ);
    assign word_addr_s = {addr_r[XLEN-1:2], 2'b00};

    assign o_ma_ready      = (state_r == IDLE);
    assign o_dmem_req      = req_s;
    assign o_dmem_we       = req_s & ~is_load_r;
    assign o_dmem_addr     = req_s ? word_addr_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
    assign o_dmem_be       = req_s ? be_s : 4'b0000;
    assign o_dmem_wdata    = req_s ? wdata_s : {XLEN{1'b0}};

    assign o_ma_valid      = ma_valid_r;
    assign o_ma_reg_write  = ma_reg_write_r;
    assign o_ma_rd_addr    = ma_rd_addr_r;
    assign o_ma_mem_to_reg = ma_mem_to_reg_r;
    assign o_ma_rw_sel     = ma_rw_sel_r;
    assign o_ma_result     = ma_result_r;
    assign o_ma_read_data  = ma_read_data_r;
    assign o_ma_pc_plus_4  = ma_pc_plus_4_r;

endmodule

// File: tb/tb_memory_access.sv
// Directed scoreboard bench for memory_access; define MA_MISALIGN_TRAP_EN to
// also exercise the misaligned trap.
module tb_memory_access;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ex_valid = 1'b0;
    logic        o_ma_ready;
    logic [31:0] i_ex_result = 32'h0;
    logic [31:0] i_ex_write_data = 32'h0;
    logic [2:0]  i_ex_funct3 = 3'b000;
    logic        i_ex_mem_read = 1'b0;
    logic        i_ex_mem_write = 1'b0;
    logic        i_ex_mem_to_reg = 1'b0;
    logic [1:0]  i_ex_rw_sel = 2'b00;
    logic [31:0] i_ex_pc_plus_4 = 32'h0;
    logic        i_ex_reg_write = 1'b0;
    logic [4:0]  i_ex_rd_addr = 5'd0;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = 32'h0;
    logic        o_ma_valid, o_ma_reg_write, o_ma_mem_to_reg;
    logic [4:0]  o_ma_rd_addr;
    logic [1:0]  o_ma_rw_sel;
    logic [31:0] o_ma_result, o_ma_read_data, o_ma_pc_plus_4;
`ifdef MA_MISALIGN_TRAP_EN
    logic        o_ma_misaligned;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regw;
        logic [31:0] pc;
        logic [1:0]  rw_sel;
        logic        m2r;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    memory_access dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ex_valid(i_ex_valid), .o_ma_ready(o_ma_ready),
        .i_ex_result(i_ex_result), .i_ex_write_data(i_ex_write_data), .i_ex_funct3(i_ex_funct3),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_mem_write(i_ex_mem_write),
        .i_ex_mem_to_reg(i_ex_mem_to_reg), .i_ex_rw_sel(i_ex_rw_sel),
        .i_ex_pc_plus_4(i_ex_pc_plus_4), .i_ex_reg_write(i_ex_reg_write),
        .i_ex_rd_addr(i_ex_rd_addr), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_ma_valid(o_ma_valid), .o_ma_reg_write(o_ma_reg_write), .o_ma_rd_addr(o_ma_rd_addr),
        .o_ma_mem_to_reg(o_ma_mem_to_reg), .o_ma_rw_sel(o_ma_rw_sel), .o_ma_result(o_ma_result),
        .o_ma_read_data(o_ma_read_data), .o_ma_pc_plus_4(o_ma_pc_plus_4)
`ifdef MA_MISALIGN_TRAP_EN
        , .o_ma_misaligned(o_ma_misaligned)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Scoreboard: every retirement pulse must match the oldest pushed expectation.
    always @(negedge i_clk) begin
        if (!i_rst && o_ma_valid) begin
            check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("wb_result", o_ma_result, e.result);
                check("wb_rd", {27'd0, o_ma_rd_addr}, {27'd0, e.rd});
                check("wb_regw", {31'd0, o_ma_reg_write}, {31'd0, e.regw});
                check("wb_pc4", o_ma_pc_plus_4, e.pc);
                check("wb_rwsel", {30'd0, o_ma_rw_sel}, {30'd0, e.rw_sel});
                check("wb_m2r", {31'd0, o_ma_mem_to_reg}, {31'd0, e.m2r});
                if (e.chk_rd) check("wb_rdata", o_ma_read_data, e.rdata);
            end
        end
    end

    // One memory instruction: accept, hold req for gnt_dly cycles, grant, then rvalid for loads.
    task automatic mem_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic [31:0] exp_rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        exp_t e;
        logic is_store;
        is_store = wr_en && !rd_en;
        i_ex_valid      = 1'b1;
        i_ex_mem_read   = rd_en;
        i_ex_mem_write  = wr_en;
        i_ex_funct3     = f3;
        i_ex_result     = addr;
        i_ex_write_data = sdata;
        i_ex_rd_addr    = rd;
        i_ex_reg_write  = rd_en;
        i_ex_mem_to_reg = rd_en;
        i_ex_rw_sel     = rd_en ? 2'b01 : 2'b00;
        i_ex_pc_plus_4  = 32'h8000_0000 | addr;
        e.result = addr; e.rd = rd; e.regw = rd_en; e.pc = 32'h8000_0000 | addr;
        e.rw_sel = rd_en ? 2'b01 : 2'b00; e.m2r = rd_en; e.chk_rd = rd_en; e.rdata = exp_rdata;
        sb_q.push_back(e);
        cyc();
        i_ex_valid = 1'b0;
        for (int i = 0; i <= gnt_dly; i++) begin
            check("req_high", {31'd0, o_dmem_req}, 32'd1);
            check("ready_low", {31'd0, o_ma_ready}, 32'd0);
            check("req_addr", o_dmem_addr, exp_addr);
            check("req_we", {31'd0, o_dmem_we}, {31'd0, is_store});
            if (is_store) begin
                check("req_be", {28'd0, o_dmem_be}, {28'd0, exp_be});
                check("req_wdata", o_dmem_wdata, exp_wdata);
            end
            if (i == gnt_dly) i_dmem_gnt = 1'b1;
            cyc();
        end
        i_dmem_gnt = 1'b0;
        if (rd_en) begin
            for (int i = 1; i < rv_dly; i++) begin
                check("wait_noreq", {31'd0, o_dmem_req}, 32'd0);
                check("wait_ready", {31'd0, o_ma_ready}, 32'd0);
                i_dmem_rdata = 32'hA5A5_5A5A;
                cyc();
            end
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = rdata;
            cyc();
            i_dmem_rvalid = 1'b0;
            i_dmem_rdata  = 32'h0;
        end
        check("retire_valid", {31'd0, o_ma_valid}, 32'd1);
        check("retire_ready", {31'd0, o_ma_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_ready", {31'd0, o_ma_ready}, 32'd1);
        check("rst_valid", {31'd0, o_ma_valid}, 32'd0);
        check("rst_req", {31'd0, o_dmem_req}, 32'd0);
        check("rst_be", {28'd0, o_dmem_be}, 32'd0);
        check("rst_result", o_ma_result, 32'd0);
        i_rst = 1'b0;
        cyc();

        // ALU instruction: latency 1, no memory request
        i_ex_valid = 1'b1; i_ex_result = 32'h0000_1234; i_ex_reg_write = 1'b1;
        i_ex_rd_addr = 5'd5; i_ex_pc_plus_4 = 32'h0000_1004; i_ex_rw_sel = 2'b10;
        e.result = 32'h0000_1234; e.rd = 5'd5; e.regw = 1'b1; e.pc = 32'h0000_1004;
        e.rw_sel = 2'b10; e.m2r = 1'b0; e.chk_rd = 1'b0; e.rdata = 32'h0;
        sb_q.push_back(e);
        check("alu_ready", {31'd0, o_ma_ready}, 32'd1);
        cyc();
        i_ex_valid = 1'b0;
        check("alu_valid", {31'd0, o_ma_valid}, 32'd1);
        check("alu_noreq", {31'd0, o_dmem_req}, 32'd0);
        cyc();
        check("bubble_valid", {31'd0, o_ma_valid}, 32'd0);
        check("bubble_regw", {31'd0, o_ma_reg_write}, 32'd0);
        check("bubble_hold", o_ma_result, 32'h0000_1234);

        // Stray rvalid in IDLE is ignored
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1234_5678;
        cyc();
        i_dmem_rvalid = 1'b0;
        check("stray_rvalid", {31'd0, o_ma_valid}, 32'd0);

        // Stores
        mem_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'hDEAD_BEEF, 5'd0, 0, 1, 32'h0, 32'h0,
               32'h0000_0100, 4'b1000, 32'hEFEF_EFEF);
        mem_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 5'd0, 1, 1, 32'h0, 32'h0,
               32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
        mem_op(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 5'd0, 0, 1, 32'h0, 32'h0,
               32'h0000_0104, 4'b1111, 32'hCAFE_F00D);

        // Loads
        mem_op(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0, 5'd7, 2, 3, 32'h0000_8000,
               32'hFFFF_FF80, 32'h0000_0200, 4'b0000, 32'h0);
        mem_op(1'b1, 1'b0, 3'b100, 32'h0000_0201, 32'h0, 5'd8, 0, 1, 32'h0000_8000,
               32'h0000_0080, 32'h0000_0200, 4'b0000, 32'h0);
        mem_op(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0, 5'd9, 0, 1, 32'hBEEF_0000,
               32'h0000_BEEF, 32'h0000_0300, 4'b0000, 32'h0);
        mem_op(1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0, 5'd10, 0, 2, 32'hBEEF_0000,
               32'hFFFF_BEEF, 32'h0000_0300, 4'b0000, 32'h0);
        mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd11, 0, 1, 32'hBEEF_0000,
               32'hBEEF_0000, 32'h0000_0300, 4'b0000, 32'h0);
        // Read and write together behave as a load
        mem_op(1'b1, 1'b1, 3'b010, 32'h0000_0204, 32'h5555_5555, 5'd12, 0, 1, 32'h1122_3344,
               32'h1122_3344, 32'h0000_0204, 4'b0000, 32'h0);

        // Reset while waiting for read data, then a late rvalid
        i_ex_valid = 1'b1; i_ex_mem_read = 1'b1; i_ex_mem_write = 1'b0; i_ex_funct3 = 3'b010;
        i_ex_result = 32'h0000_0300; i_ex_rd_addr = 5'd13; i_ex_reg_write = 1'b1;
        cyc();
        i_ex_valid = 1'b0; i_dmem_gnt = 1'b1;
        cyc();
        i_dmem_gnt = 1'b0;
        check("rr_wait_noreq", {31'd0, o_dmem_req}, 32'd0);
        check("rr_wait_ready", {31'd0, o_ma_ready}, 32'd0);
        i_rst = 1'b1;
        #1;
        check("rr_req", {31'd0, o_dmem_req}, 32'd0);
        check("rr_ready", {31'd0, o_ma_ready}, 32'd1);
        check("rr_result", o_ma_result, 32'd0);
        check("rr_rdata", o_ma_read_data, 32'd0);
        check("rr_rd", {27'd0, o_ma_rd_addr}, 32'd0);
        check("rr_pc4", o_ma_pc_plus_4, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h7777_7777;
        cyc();
        i_dmem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rr_novalid", {31'd0, o_ma_valid}, 32'd0);
            check("rr_idle", {31'd0, o_ma_ready}, 32'd1);
            cyc();
        end

`ifdef MA_MISALIGN_TRAP_EN
        // Misaligned word load traps in one cycle without a request
        i_ex_valid = 1'b1; i_ex_mem_read = 1'b1; i_ex_mem_write = 1'b0; i_ex_funct3 = 3'b010;
        i_ex_result = 32'h0000_0402; i_ex_rd_addr = 5'd14; i_ex_reg_write = 1'b1;
        i_ex_pc_plus_4 = 32'h0000_2000; i_ex_rw_sel = 2'b01; i_ex_mem_to_reg = 1'b1;
        e.result = 32'h0000_0402; e.rd = 5'd14; e.regw = 1'b0; e.pc = 32'h0000_2000;
        e.rw_sel = 2'b01; e.m2r = 1'b1; e.chk_rd = 1'b0; e.rdata = 32'h0;
        sb_q.push_back(e);
        cyc();
        i_ex_valid = 1'b0;
        check("mis_noreq", {31'd0, o_dmem_req}, 32'd0);
        check("mis_valid", {31'd0, o_ma_valid}, 32'd1);
        check("mis_flag", {31'd0, o_ma_misaligned}, 32'd1);
        check("mis_regw", {31'd0, o_ma_reg_write}, 32'd0);
        cyc();
        check("mis_flag_drop", {31'd0, o_ma_misaligned}, 32'd0);
`endif

        cyc();
        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
